// File: rtl/mem_arbiter_if.sv
// Requester-side bus of the two-port memory arbiter: fetch (0) and data (1)
// requests in, per-requester completion pulses and shared read data out.
interface mem_arbiter_if #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 8
);
  logic              req0;
  logic              req1;
  logic              we0;
  logic              we1;
  logic [ADDR_W-1:0] addr0;
  logic [ADDR_W-1:0] addr1;
  logic [DATA_W-1:0] wdata0;
  logic [DATA_W-1:0] wdata1;
  logic              done0;
  logic              done1;
  logic [DATA_W-1:0] rdata;
  logic              busy;

  modport slave (
    input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1,
    output done0, done1, rdata, busy
  );

  modport master (
    output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1,
    input  done0, done1, rdata, busy
  );
endinterface

// File: rtl/mem_arbiter.sv
// Two-requester round-robin arbiter in front of a single-port memory.
// Each access takes IDLE -> ACCESS -> RESP, i.e. one access every 3 cycles.
module mem_arbiter #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  mem_arbiter_if.slave      bus,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  state_t            state_r;
  state_t            state_nxt_s;
  logic              grant_s;
  logic              win_s;
  logic              last_r;
  logic              mem_we_q_r;
  logic [ADDR_W-1:0] mem_addr_r;
  logic [DATA_W-1:0] mem_wdata_r;
  logic [DATA_W-1:0] rdata_r;
  logic              done0_r;
  logic              done1_r;

  // Next-state and arbitration decision
  always_comb begin
    state_nxt_s = state_r;
    grant_s     = 1'b0;
    win_s       = 1'b0;
    case (state_r)
      IDLE: begin
        if (bus.req0 || bus.req1) begin
          grant_s     = 1'b1;
          state_nxt_s = ACCESS;
          // On a tie the requester not served last wins
          if (bus.req0 && bus.req1) begin
            win_s = ~last_r;
          end else if (bus.req1) begin
            win_s = 1'b1;
          end else begin
            win_s = 1'b0;
          end
        end else begin
          state_nxt_s = IDLE;
        end
      end
      ACCESS:  state_nxt_s = RESP;
      RESP:    state_nxt_s = IDLE;
      default: state_nxt_s = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Grant capture: winner's command is frozen until the next grant
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_r      <= 1'b1;
      mem_we_q_r  <= 1'b0;
      mem_addr_r  <= '0;
      mem_wdata_r <= '0;
    end else if (grant_s) begin
      last_r      <= win_s;
      mem_we_q_r  <= win_s ? bus.we1    : bus.we0;
      mem_addr_r  <= win_s ? bus.addr1  : bus.addr0;
      mem_wdata_r <= win_s ? bus.wdata1 : bus.wdata0;
    end else begin
      last_r      <= last_r;
      mem_we_q_r  <= mem_we_q_r;
      mem_addr_r  <= mem_addr_r;
      mem_wdata_r <= mem_wdata_r;
    end
  end

  // Response: memory already holds write data by the end of ACCESS
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata_r <= '0;
      done0_r <= 1'b0;
      done1_r <= 1'b0;
    end else begin
      rdata_r <= (state_r == ACCESS) ? mem_rdata : rdata_r;
      done0_r <= (state_r == ACCESS) && !last_r;
      done1_r <= (state_r == ACCESS) &&  last_r;
    end
  end

  assign mem_we    = mem_we_q_r && (state_r == ACCESS);
  assign mem_addr  = mem_addr_r;
  assign mem_wdata = mem_wdata_r;
  assign bus.rdata = rdata_r;
  assign bus.done0 = done0_r;
  assign bus.done1 = done1_r;
  assign bus.busy  = (state_r != IDLE);

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios plus randomized
// traffic compared every cycle against a transaction-level reference model.
module tb_mem_arbiter;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       mem_we;
  logic [4:0] mem_addr;
  logic [7:0] mem_wdata;
  logic [7:0] mem_rdata;

  int n_chk  = 0;
  int n_fail = 0;

  mem_arbiter_if #(.ADDR_W(5), .DATA_W(8)) bus ();

  mem_arbiter #(.ADDR_W(5), .DATA_W(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata)
  );

  always #5 clk = ~clk;

  // Physical memory: combinational read, write on falling edge
  logic [7:0] phys_mem [32];
  assign mem_rdata = phys_mem[mem_addr];
  always @(negedge clk) if (mem_we) phys_mem[mem_addr] <= mem_wdata;

  // Reference model: one transaction record walked through 3 phases
  logic [7:0] ref_mem [32];
  int         m_phase = 0;     // 0 idle, 1 memory access, 2 response
  bit         m_who   = 1'b0;
  bit         m_last  = 1'b1;
  bit         m_we    = 1'b0;
  logic [4:0] m_addr  = 5'd0;
  logic [7:0] m_wdata = 8'd0;
  logic [7:0] m_rdata = 8'd0;

  always @(negedge rst_n) begin
    m_phase = 0; m_last = 1'b1; m_we = 1'b0;
    m_addr = 5'd0; m_wdata = 8'd0; m_rdata = 8'd0;
  end

  always @(posedge clk) begin
    if (rst_n) begin
      if (m_phase == 0) begin
        if (bus.req0 || bus.req1) begin
          if (bus.req0 && bus.req1) m_who = !m_last;
          else                      m_who = bus.req1;
          m_last  = m_who;
          m_we    = m_who ? bus.we1    : bus.we0;
          m_addr  = m_who ? bus.addr1  : bus.addr0;
          m_wdata = m_who ? bus.wdata1 : bus.wdata0;
          m_phase = 1;
        end
      end else if (m_phase == 1) begin
        if (m_we) begin
          ref_mem[m_addr] = m_wdata;
          m_rdata = m_wdata;
        end else begin
          m_rdata = ref_mem[m_addr];
        end
        m_phase = 2;
      end else begin
        m_phase = 0;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model
  always @(negedge clk) begin
    chk("busy",      32'(bus.busy),  32'(m_phase != 0));
    chk("done0",     32'(bus.done0), 32'(m_phase == 2 && !m_who));
    chk("done1",     32'(bus.done1), 32'(m_phase == 2 &&  m_who));
    chk("rdata",     32'(bus.rdata), 32'(m_rdata));
    chk("mem_addr",  32'(mem_addr),  32'(m_addr));
    chk("mem_wdata", 32'(mem_wdata), 32'(m_wdata));
    chk("mem_we",    32'(mem_we),    32'(m_phase == 1 && m_we));
  end

  task automatic idle_inputs();
    bus.req0 = 1'b0; bus.req1 = 1'b0; bus.we0 = 1'b0; bus.we1 = 1'b0;
    bus.addr0 = 5'd0; bus.addr1 = 5'd0; bus.wdata0 = 8'd0; bus.wdata1 = 8'd0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_mem_we"},    32'(mem_we),    32'd0);
    chk({tag, "_mem_addr"},  32'(mem_addr),  32'd0);
    chk({tag, "_mem_wdata"}, 32'(mem_wdata), 32'd0);
    chk({tag, "_rdata"},     32'(bus.rdata), 32'd0);
    chk({tag, "_done"},      32'({bus.done0, bus.done1}), 32'd0);
    chk({tag, "_busy"},      32'(bus.busy),  32'd0);
  endtask

  // Single access, req dropped one cycle after the grant
  task automatic do_req(input bit who, input bit we, input logic [4:0] addr,
                        input logic [7:0] wd, input logic [7:0] exp);
    @(negedge clk);
    if (who) begin bus.req1 = 1'b1; bus.we1 = we; bus.addr1 = addr; bus.wdata1 = wd; end
    else     begin bus.req0 = 1'b1; bus.we0 = we; bus.addr0 = addr; bus.wdata0 = wd; end
    @(negedge clk);
    bus.req0 = 1'b0; bus.req1 = 1'b0;
    chk("lit_busy_access", 32'(bus.busy), 32'd1);
    @(negedge clk);
    chk("lit_done_winner", 32'(who ? bus.done1 : bus.done0), 32'd1);
    chk("lit_done_other",  32'(who ? bus.done0 : bus.done1), 32'd0);
    chk("lit_rdata",       32'(bus.rdata), 32'(exp));
    chk("lit_model_rdata", 32'(m_rdata),   32'(exp));
    chk("lit_busy_resp",   32'(bus.busy),  32'd1);
    @(negedge clk);
    chk("lit_busy_idle",   32'(bus.busy),  32'd0);
  endtask

  initial begin
    for (int i = 0; i < 32; i++) begin
      phys_mem[i] = 8'($urandom);
      ref_mem[i]  = phys_mem[i];
    end
    phys_mem[25] = 8'd9;   ref_mem[25] = 8'd9;
    phys_mem[26] = 8'd7;   ref_mem[26] = 8'd7;
    phys_mem[27] = 8'd5;   ref_mem[27] = 8'd5;
    phys_mem[29] = 8'd1;   ref_mem[29] = 8'd1;
    phys_mem[9]  = 8'hBE;  ref_mem[9]  = 8'hBE;
    idle_inputs();

    repeat (3) @(negedge clk);
    chk_all_zero("reset");
    rst_n = 1'b1;

    // Tie right after reset: 0, 1, 0
    bus.req0 = 1'b1; bus.addr0 = 5'd26;
    bus.req1 = 1'b1; bus.addr1 = 5'd27;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      if (c == 2) begin
        chk("tie_done0_a", 32'(bus.done0), 32'd1);
        chk("tie_rdata_a", 32'(bus.rdata), 32'd7);
      end
      if (c == 5) begin
        chk("tie_done1", 32'(bus.done1), 32'd1);
        chk("tie_rdata_b", 32'(bus.rdata), 32'd5);
      end
      if (c == 8) begin
        chk("tie_done0_c", 32'(bus.done0), 32'd1);
        chk("tie_rdata_c", 32'(bus.rdata), 32'd7);
        idle_inputs();
      end
    end

    do_req(1'b0, 1'b0, 5'd25, 8'd0,  8'd9);
    do_req(1'b1, 1'b1, 5'd5,  8'hA5, 8'hA5);
    do_req(1'b1, 1'b0, 5'd5,  8'd0,  8'hA5);
    chk("mem5", 32'(phys_mem[5]), 32'hA5);
    do_req(1'b0, 1'b0, 5'd29, 8'd0,  8'd1);
    do_req(1'b1, 1'b0, 5'd31, 8'd0,  ref_mem[31]);

    // Reset hits right after the grant of a write, before the falling edge
    @(negedge clk);
    bus.req0 = 1'b1; bus.we0 = 1'b1; bus.addr0 = 5'd9; bus.wdata0 = 8'hFF;
    @(posedge clk);
    #2 rst_n = 1'b0;
    idle_inputs();
    @(negedge clk);
    chk_all_zero("rst_abort");
    @(negedge clk);
    chk("rst_mem9", 32'(phys_mem[9]), 32'hBE);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_mem9_after", 32'(phys_mem[9]), 32'hBE);

    // Randomized traffic with occasional asynchronous reset
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      if ($urandom_range(0, 249) == 0) begin
        #1 rst_n = 1'b0;
        @(negedge clk);
        #1 rst_n = 1'b1;
      end else begin
        bus.req0   = ($urandom_range(0, 1) == 1);
        bus.req1   = ($urandom_range(0, 1) == 1);
        bus.we0    = ($urandom_range(0, 2) == 0);
        bus.we1    = ($urandom_range(0, 2) == 0);
        bus.addr0  = 5'($urandom);
        bus.addr1  = 5'($urandom);
        bus.wdata0 = 8'($urandom);
        bus.wdata1 = 8'($urandom);
      end
    end
    idle_inputs();
    repeat (4) @(negedge clk);

    for (int i = 0; i < 32; i++) chk("final_mem", 32'(phys_mem[i]), 32'(ref_mem[i]));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
